// File: rtl/axi_wr_burst_sched.sv
// Burst command scheduler for the stream-to-memory write path: walks a DDR ring one
// burst at a time, caps bursts in flight, and retires them on AXI B responses.
module axi_wr_burst_sched #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int AW_LIN     = 16,
  parameter int MAX_OUTST  = 4
) (
  input  logic                  m_axi_aclk,
  input  logic                  m_axi_areset,
  input  logic                  cfg_start,
  input  logic                  cfg_stop,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [15:0]           cfg_ring_bursts,
  input  logic [31:0]           cfg_num_bursts,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic [7:0]            cmd_len,
  input  logic                  m_axi_bvalid,
  input  logic [1:0]            m_axi_bresp,
  output logic                  m_axi_bready,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [3:0]            outstanding,
  output logic [31:0]           bursts_done
);

  localparam int              BB_BYTES = AW_LIN * DATA_WIDTH / 8;
  localparam int              BB_SH    = $clog2(BB_BYTES);
  localparam logic [7:0]      LEN_C    = 8'(AW_LIN - 1);
  localparam logic [3:0]      MAX_O    = 4'(MAX_OUTST);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                  state_r, state_nxt_s;
  logic [ADDR_WIDTH-1:0]   base_r, base_nxt_s;
  logic [15:0]             ring_r, ring_nxt_s;
  logic [31:0]             num_r, num_nxt_s;
  logic [31:0]             issued_r, issued_nxt_s;
  logic [15:0]             idx_r, idx_nxt_s;
  logic                    stop_r, stop_nxt_s;
  logic                    cmd_valid_r, cmd_valid_nxt_s;
  logic [ADDR_WIDTH-1:0]   cmd_addr_r, cmd_addr_nxt_s;
  logic                    bready_r;
  logic                    busy_r, busy_nxt_s;
  logic                    done_r, done_nxt_s;
  logic                    err_r, err_nxt_s;
  logic [3:0]              outst_r, outst_nxt_s;
  logic [31:0]             bdone_r, bdone_nxt_s;

  logic                    cmd_hs_s, b_hs_s, hold_s, stop_any_s, fin_s, more_s;
  logic [15:0]             idx_inc_s;
  logic [31:0]             issued_inc_s;
  logic [3:0]              outst_upd_s;

  // Handshake decode and the per-cycle counter arithmetic shared by every state.
  always_comb begin
    cmd_hs_s     = cmd_valid_r & cmd_ready;
    b_hs_s       = m_axi_bvalid & bready_r & (outst_r != 4'd0);
    hold_s       = cmd_valid_r & ~cmd_ready;
    idx_inc_s    = (idx_r >= ring_r - 16'd1) ? 16'd0 : idx_r + 16'd1;
    issued_inc_s = issued_r + {31'd0, cmd_hs_s};
    case ({cmd_hs_s, b_hs_s})
      2'b10:   outst_upd_s = outst_r + 4'd1;
      2'b01:   outst_upd_s = outst_r - 4'd1;
      default: outst_upd_s = outst_r;
    endcase
    stop_any_s = stop_r | cfg_stop;
    fin_s      = stop_any_s | ((num_r != 32'd0) & (issued_inc_s == num_r));
    more_s     = ~fin_s & (outst_upd_s < MAX_O);
  end

  // Next-state and next-register values for the run FSM.
  always_comb begin
    state_nxt_s     = state_r;
    base_nxt_s      = base_r;
    ring_nxt_s      = ring_r;
    num_nxt_s       = num_r;
    issued_nxt_s    = issued_inc_s;
    idx_nxt_s       = cmd_hs_s ? idx_inc_s : idx_r;
    stop_nxt_s      = stop_r;
    cmd_valid_nxt_s = cmd_valid_r;
    cmd_addr_nxt_s  = cmd_hs_s ? base_r + (ADDR_WIDTH'(idx_inc_s) << BB_SH) : cmd_addr_r;
    busy_nxt_s      = busy_r;
    done_nxt_s      = 1'b0;
    err_nxt_s       = err_r | (b_hs_s & (m_axi_bresp != 2'b00));
    outst_nxt_s     = outst_upd_s;
    bdone_nxt_s     = bdone_r + {31'd0, b_hs_s};
    case (state_r)
      S_IDLE: begin
        if (cfg_start) begin
          state_nxt_s     = S_ISSUE;
          base_nxt_s      = cfg_base_addr;
          ring_nxt_s      = (cfg_ring_bursts == 16'd0) ? 16'd1 : cfg_ring_bursts;
          num_nxt_s       = cfg_num_bursts;
          issued_nxt_s    = 32'd0;
          idx_nxt_s       = 16'd0;
          stop_nxt_s      = 1'b0;
          err_nxt_s       = 1'b0;
          bdone_nxt_s     = 32'd0;
          busy_nxt_s      = 1'b1;
          cmd_valid_nxt_s = (outst_upd_s < MAX_O);
          cmd_addr_nxt_s  = cfg_base_addr;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        stop_nxt_s = stop_any_s;
        // A presented command is never withdrawn, even after stop or a B response.
        if (hold_s) begin
          cmd_valid_nxt_s = 1'b1;
        end else begin
          cmd_valid_nxt_s = more_s;
          if (fin_s) begin
            state_nxt_s = S_DRAIN;
          end else begin
            state_nxt_s = S_ISSUE;
          end
        end
      end
      S_DRAIN: begin
        if (outst_r == 4'd0) begin
          state_nxt_s = S_DONE;
          done_nxt_s  = 1'b1;
          busy_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = S_DRAIN;
        end
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State and output registers; reset forgets any bursts still in flight.
  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      state_r     <= S_IDLE;
      base_r      <= '0;
      ring_r      <= 16'd1;
      num_r       <= 32'd0;
      issued_r    <= 32'd0;
      idx_r       <= 16'd0;
      stop_r      <= 1'b0;
      cmd_valid_r <= 1'b0;
      cmd_addr_r  <= '0;
      bready_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      outst_r     <= 4'd0;
      bdone_r     <= 32'd0;
    end else begin
      state_r     <= state_nxt_s;
      base_r      <= base_nxt_s;
      ring_r      <= ring_nxt_s;
      num_r       <= num_nxt_s;
      issued_r    <= issued_nxt_s;
      idx_r       <= idx_nxt_s;
      stop_r      <= stop_nxt_s;
      cmd_valid_r <= cmd_valid_nxt_s;
      cmd_addr_r  <= cmd_addr_nxt_s;
      bready_r    <= 1'b1;
      busy_r      <= busy_nxt_s;
      done_r      <= done_nxt_s;
      err_r       <= err_nxt_s;
      outst_r     <= outst_nxt_s;
      bdone_r     <= bdone_nxt_s;
    end
  end

  assign cmd_valid    = cmd_valid_r;
  assign cmd_addr     = cmd_addr_r;
  assign cmd_len      = LEN_C;
  assign m_axi_bready = bready_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign err          = err_r;
  assign outstanding  = outst_r;
  assign bursts_done  = bdone_r;

endmodule

// File: tb/tb_axi_wr_burst_sched.sv
// Directed-plus-random bench for axi_wr_burst_sched with a ring/credit reference model.
module tb_axi_wr_burst_sched;

  localparam int BB   = 128;
  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start, cfg_stop;
  logic [31:0] cfg_base_addr;
  logic [15:0] cfg_ring_bursts;
  logic [31:0] cfg_num_bursts;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        m_axi_bvalid, m_axi_bready;
  logic [1:0]  m_axi_bresp;
  logic        busy, done, err;
  logic [3:0]  outstanding;
  logic [31:0] bursts_done;

  axi_wr_burst_sched dut (
    .m_axi_aclk(clk), .m_axi_areset(rst),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_base_addr(cfg_base_addr),
    .cfg_ring_bursts(cfg_ring_bursts), .cfg_num_bursts(cfg_num_bursts),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bresp(m_axi_bresp), .m_axi_bready(m_axi_bready),
    .busy(busy), .done(done), .err(err), .outstanding(outstanding), .bursts_done(bursts_done)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // reference model state
  logic [31:0] exp_base;
  int          exp_ring = 1;
  int          cmds_run = 0, mdl_outst = 0, mdl_bdone = 0, done_cnt = 0, same_cyc = 0;
  bit          mdl_err = 1'b0, clear_req = 1'b0, mon_en = 1'b0;
  logic [31:0] got_addrs[$];
  int          pend[$];
  bit          prev_valid = 1'b0, prev_pend = 1'b0, prev_done = 1'b0;
  logic [31:0] prev_addr = 32'd0;

  // stimulus knobs
  int cyc = 0, b_credit = 0, b_sent = 0, err_idx = -1;
  bit b_en = 1'b1, rdy_rand = 1'b0, rdy_fixed = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    cmd_ready    = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
    m_axi_bvalid = 1'b0;
    m_axi_bresp  = 2'b00;
    if (pend.size() > 0 && pend[0] <= cyc && (b_en || b_credit > 0)) begin
      if (!b_en) b_credit--;
      void'(pend.pop_front());
      m_axi_bvalid = 1'b1;
      m_axi_bresp  = (b_sent == err_idx) ? 2'b10 : 2'b00;
      b_sent++;
    end
  endtask

  task automatic start_run(input logic [31:0] base, input logic [15:0] ring, input logic [31:0] num);
    cfg_base_addr   = base;
    cfg_ring_bursts = ring;
    cfg_num_bursts  = num;
    cfg_start       = 1'b1;
    clear_req       = 1'b1;
    step();
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) step();
    chk("done_timeout", 32'(done_cnt > d0), 32'd1);
  endtask

  // Negedge monitor: compare against the model, then fold in the handshakes of the coming edge.
  always @(negedge clk) begin
    if (!rst && mon_en) begin
      bit ch, bh;
      chk("bready", 32'(m_axi_bready), 32'd1);
      chk("outstanding", 32'(outstanding), 32'(mdl_outst));
      chk("bursts_done", bursts_done, 32'(mdl_bdone));
      chk("err", 32'(err), 32'(mdl_err));
      if (prev_pend) begin
        chk("hold_valid", 32'(cmd_valid), 32'd1);
        chk("hold_addr", cmd_addr, prev_addr);
      end
      if (cmd_valid && !prev_valid) chk("rise_below_max", 32'(outstanding < MAXO), 32'd1);
      if (done) begin
        chk("done_busy_low", 32'(busy), 32'd0);
        chk("done_one_cycle", 32'(prev_done), 32'd0);
        done_cnt++;
      end
      if (cfg_start && clear_req) begin
        clear_req = 1'b0;
        exp_base  = cfg_base_addr;
        exp_ring  = (cfg_ring_bursts == 16'd0) ? 1 : int'(cfg_ring_bursts);
        cmds_run  = 0;
        mdl_bdone = 0;
        mdl_err   = 1'b0;
        got_addrs.delete();
      end
      ch = cmd_valid && cmd_ready;
      bh = m_axi_bvalid && (mdl_outst > 0);
      if (ch) begin
        chk("cmd_addr", cmd_addr, exp_base + 32'((cmds_run % exp_ring) * BB));
        got_addrs.push_back(cmd_addr);
        cmds_run++;
        pend.push_back(cyc + 3);
      end
      if (bh) begin
        mdl_bdone++;
        if (m_axi_bresp != 2'b00) mdl_err = 1'b1;
      end
      if (ch && bh) same_cyc++;
      mdl_outst  = mdl_outst + int'(ch) - int'(bh);
      prev_valid = cmd_valid;
      prev_pend  = cmd_valid && !cmd_ready;
      prev_addr  = cmd_addr;
      prev_done  = done;
    end
  end

  initial begin
    int c0, d0;
    rst = 1'b1; cfg_start = 1'b0; cfg_stop = 1'b0; cfg_base_addr = 32'd0;
    cfg_ring_bursts = 16'd0; cfg_num_bursts = 32'd0; cmd_ready = 1'b0;
    m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    repeat (3) step();
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_cmd_addr", cmd_addr, 32'd0);
    chk("rst_cmd_len", 32'(cmd_len), 32'd15);
    chk("rst_bready", 32'(m_axi_bready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step();
    mon_en = 1'b1;

    // 1: four bursts, linear addresses
    d0 = done_cnt;
    start_run(32'h1000_0000, 16'd8, 32'd4);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_done(500);
    repeat (5) step();
    chk("t1_done_once", 32'(done_cnt - d0), 32'd1);
    chk("t1_cmds", 32'(cmds_run), 32'd4);
    chk("t1_addr0", got_addrs[0], 32'h1000_0000);
    chk("t1_addr3", got_addrs[3], 32'h1000_0180);
    chk("t1_bdone", bursts_done, 32'd4);
    chk("t1_err", 32'(err), 32'd0);

    // 2: ring of 3, random ready, then ring size 0
    rdy_rand = 1'b1;
    start_run(32'h2000_0000, 16'd3, 32'd7);
    wait_done(2000);
    chk("t2_cmds", 32'(cmds_run), 32'd7);
    chk("t2_addr2", got_addrs[2], 32'h2000_0100);
    chk("t2_addr3", got_addrs[3], 32'h2000_0000);
    chk("t2_addr6", got_addrs[6], 32'h2000_0000);
    chk("t2_bdone", bursts_done, 32'd7);
    start_run(32'h2100_0000, 16'd0, 32'd3);
    wait_done(2000);
    chk("t2b_addr2", got_addrs[2], 32'h2100_0000);
    rdy_rand = 1'b0; rdy_fixed = 1'b1;

    // 3: withheld B throttles at MAX_OUTST; start while busy is ignored
    b_en = 1'b0;
    start_run(32'h3000_0000, 16'd16, 32'd0);
    repeat (20) step();
    chk("t3_cmds", 32'(cmds_run), 32'd4);
    chk("t3_valid_low", 32'(cmd_valid), 32'd0);
    chk("t3_outst", 32'(outstanding), 32'd4);
    cfg_base_addr = 32'h3F00_0000; cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    b_credit = 1;
    step();
    step();
    chk("t3_one_more_valid", 32'(cmd_valid), 32'd1);
    chk("t3_outst3", 32'(outstanding), 32'd3);
    step();
    chk("t3_cmds5", 32'(cmds_run), 32'd5);
    chk("t3_valid_low2", 32'(cmd_valid), 32'd0);

    // 4: ready low while B drains, then stop with a command pending
    rdy_fixed = 1'b0; b_en = 1'b1;
    repeat (5) step();
    chk("t4_valid_held", 32'(cmd_valid), 32'd1);
    c0 = cmds_run;
    chk("t4_no_hs", 32'(c0), 32'd5);
    cfg_stop = 1'b1;
    step();
    cfg_stop = 1'b0;
    repeat (3) step();
    rdy_fixed = 1'b1;
    wait_done(500);
    chk("t4_pending_done", 32'(cmds_run), 32'(c0 + 1));
    chk("t4_outst0", 32'(outstanding), 32'd0);

    // 5: continuous run stopped after 10 commands, one error response
    b_en = 1'b0;
    err_idx = b_sent + 5;
    start_run(32'h4000_0000, 16'd8, 32'd0);
    repeat (10) step();
    for (int k = 0; k < 6; k++) begin
      b_credit = 1;
      repeat (4) step();
    end
    chk("t5_cmds10", 32'(cmds_run), 32'd10);
    chk("t5_valid_low", 32'(cmd_valid), 32'd0);
    cfg_stop = 1'b1;
    step();
    cfg_stop = 1'b0;
    d0 = done_cnt;
    for (int k = 0; k < 3; k++) begin
      b_credit = 1;
      repeat (3) step();
    end
    chk("t5_not_done", 32'(done_cnt - d0), 32'd0);
    chk("t5_still_busy", 32'(busy), 32'd1);
    b_credit = 1;
    wait_done(200);
    chk("t5_no_11th", 32'(cmds_run), 32'd10);
    chk("t5_err", 32'(err), 32'd1);
    repeat (5) step();
    chk("t5_err_sticky", 32'(err), 32'd1);
    chk("t5_bdone_hold", bursts_done, 32'd10);
    b_en = 1'b1;

    // 6: reset in the middle of a continuous run, then start+stop together
    start_run(32'h5000_0000, 16'd5, 32'd0);
    step();
    chk("t6_err_cleared", 32'(err), 32'd0);
    repeat (30) step();
    chk("t6_same_cycle_seen", 32'(same_cyc > 0), 32'd1);
    rst = 1'b1; mon_en = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(cmd_valid), 32'd0);
    chk("t6_rst_outst", 32'(outstanding), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_bdone", bursts_done, 32'd0);
    chk("t6_rst_bready", 32'(m_axi_bready), 32'd0);
    pend.delete();
    mdl_outst = 0; mdl_bdone = 0; mdl_err = 1'b0;
    prev_valid = 1'b0; prev_pend = 1'b0; prev_done = 1'b0;
    step();
    rst = 1'b0;
    step();
    mon_en = 1'b1;
    cfg_stop = 1'b1;
    start_run(32'h6000_0000, 16'd4, 32'd2);
    cfg_stop = 1'b0;
    wait_done(500);
    chk("t6_cmds", 32'(cmds_run), 32'd2);
    chk("t6_addr1", got_addrs[1], 32'h6000_0080);
    chk("t6_bdone", bursts_done, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
